// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-master memory port arbiter.
// Holds the FSM state encoding and the default stall timeout.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2,
        ST_ABORT = 2'd3
    } arb_state_t;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter giving an instruction master and a data master access to one shared
// Wishbone-style memory port, with bus locking and a stall-timeout abort.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] iaddr_i,
    input  logic        icyc_i,
    input  logic        istb_i,
    output logic [31:0] idat_o,
    output logic        iack_o,
    output logic        ierr_o,
    input  logic [31:0] daddr_i,
    input  logic [31:0] ddat_i,
    input  logic [3:0]  dsel_i,
    input  logic        dcyc_i,
    input  logic        dstb_i,
    input  logic        dwe_i,
    output logic [31:0] ddat_o,
    output logic        dack_o,
    output logic        derr_o,
    output logic [31:0] maddr_o,
    output logic [31:0] mdat_o,
    output logic [3:0]  msel_o,
    output logic        mcyc_o,
    output logic        mstb_o,
    output logic        mwe_o,
    input  logic [31:0] mdat_i,
    input  logic        mack_i,
    input  logic        merr_i
);

    arb_state_t  state;
    logic [7:0]  stall_cnt;
    logic        owner_d;     // last / current owner: 1 = data master, 0 = instruction master
    logic        abort_err;   // one-cycle error pulse on entry to ABORT

    logic        ireq;
    logic        dreq;
    logic        own_cyc;
    logic        own_stb;
    logic [7:0]  stall_nxt;

    assign ireq      = icyc_i & istb_i;
    assign dreq      = dcyc_i & dstb_i;
    assign own_cyc   = owner_d ? dcyc_i : icyc_i;
    assign own_stb   = owner_d ? dstb_i : istb_i;
    assign stall_nxt = stall_cnt + 8'd1;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= ST_IDLE;
            stall_cnt <= 8'd0;
            owner_d   <= 1'b0;
            abort_err <= 1'b0;
        end else begin
            abort_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    stall_cnt <= 8'd0;
                    // On a tie the master that did not own the bus last time wins.
                    if (ireq && dreq) begin
                        owner_d <= ~owner_d;
                        state   <= owner_d ? ST_GNT_I : ST_GNT_D;
                    end else if (dreq) begin
                        owner_d <= 1'b1;
                        state   <= ST_GNT_D;
                    end else if (ireq) begin
                        owner_d <= 1'b0;
                        state   <= ST_GNT_I;
                    end
                end
                ST_GNT_I, ST_GNT_D: begin
                    if (!own_cyc) begin
                        state     <= ST_IDLE;
                        stall_cnt <= 8'd0;
                    end else if (mack_i || merr_i) begin
                        stall_cnt <= 8'd0;
                    end else if (own_stb) begin
                        stall_cnt <= stall_nxt;
                        if (stall_nxt == 8'(TIMEOUT)) begin
                            state     <= ST_ABORT;
                            abort_err <= 1'b1;
                        end
                    end
                end
                ST_ABORT: begin
                    if (!own_cyc) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bus steering: the owner drives the shared port and alone sees its responses.
    always_comb begin
        maddr_o = 32'd0;
        mdat_o  = 32'd0;
        msel_o  = 4'd0;
        mcyc_o  = 1'b0;
        mstb_o  = 1'b0;
        mwe_o   = 1'b0;
        idat_o  = 32'd0;
        iack_o  = 1'b0;
        ierr_o  = 1'b0;
        ddat_o  = 32'd0;
        dack_o  = 1'b0;
        derr_o  = 1'b0;
        case (state)
            ST_GNT_I: begin
                maddr_o = iaddr_i;
                msel_o  = 4'hf;
                mcyc_o  = icyc_i;
                mstb_o  = istb_i;
                idat_o  = mdat_i;
                iack_o  = mack_i;
                ierr_o  = merr_i;
            end
            ST_GNT_D: begin
                maddr_o = daddr_i;
                mdat_o  = ddat_i;
                msel_o  = dsel_i;
                mcyc_o  = dcyc_i;
                mstb_o  = dstb_i;
                mwe_o   = dwe_i;
                ddat_o  = mdat_i;
                dack_o  = mack_i;
                derr_o  = merr_i;
            end
            ST_ABORT: begin
                ierr_o = abort_err & ~owner_d;
                derr_o = abort_err & owner_d;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter (TIMEOUT=4).
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        iack;
        logic        ierr;
        logic        dack;
        logic        derr;
        logic [31:0] idat;
        logic [31:0] ddat;
        logic [31:0] maddr;
        logic [31:0] mdat;
        logic [3:0]  msel;
        logic        mwe;
    } resp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] iaddr_i = '0;
    logic        icyc_i = 1'b0;
    logic        istb_i = 1'b0;
    logic [31:0] idat_o;
    logic        iack_o;
    logic        ierr_o;
    logic [31:0] daddr_i = '0;
    logic [31:0] ddat_i = '0;
    logic [3:0]  dsel_i = '0;
    logic        dcyc_i = 1'b0;
    logic        dstb_i = 1'b0;
    logic        dwe_i = 1'b0;
    logic [31:0] ddat_o;
    logic        dack_o;
    logic        derr_o;
    logic [31:0] maddr_o;
    logic [31:0] mdat_o;
    logic [3:0]  msel_o;
    logic        mcyc_o;
    logic        mstb_o;
    logic        mwe_o;
    logic [31:0] mdat_i = '0;
    logic        mack_i = 1'b0;
    logic        merr_i = 1'b0;

    int    n_vec = 0;
    int    n_err = 0;
    resp_t exp_q[$];

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .iaddr_i(iaddr_i), .icyc_i(icyc_i), .istb_i(istb_i),
        .idat_o(idat_o), .iack_o(iack_o), .ierr_o(ierr_o),
        .daddr_i(daddr_i), .ddat_i(ddat_i), .dsel_i(dsel_i),
        .dcyc_i(dcyc_i), .dstb_i(dstb_i), .dwe_i(dwe_i),
        .ddat_o(ddat_o), .dack_o(dack_o), .derr_o(derr_o),
        .maddr_o(maddr_o), .mdat_o(mdat_o), .msel_o(msel_o),
        .mcyc_o(mcyc_o), .mstb_o(mstb_o), .mwe_o(mwe_o),
        .mdat_i(mdat_i), .mack_i(mack_i), .merr_i(merr_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic resp_t mk(logic iack, logic ierr, logic dack, logic derr,
                                 logic [31:0] idat, logic [31:0] ddat, logic [31:0] maddr,
                                 logic [31:0] mdat, logic [3:0] msel, logic mwe);
        resp_t r;
        r.iack = iack; r.ierr = ierr; r.dack = dack; r.derr = derr;
        r.idat = idat; r.ddat = ddat; r.maddr = maddr; r.mdat = mdat;
        r.msel = msel; r.mwe = mwe;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: any master-side response is popped against the scoreboard.
    always @(negedge clk_i) begin
        resp_t got;
        resp_t exp;
        if (iack_o || ierr_o || dack_o || derr_o) begin
            got = mk(iack_o, ierr_o, dack_o, derr_o, idat_o, ddat_o, maddr_o, mdat_o, msel_o, mwe_o);
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_resp: got ia=%b ie=%b da=%b de=%b idat=%h ddat=%h expected none",
                         got.iack, got.ierr, got.dack, got.derr, got.idat, got.ddat);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL resp: got ia=%b ie=%b da=%b de=%b idat=%h ddat=%h maddr=%h mdat=%h msel=%h mwe=%b expected ia=%b ie=%b da=%b de=%b idat=%h ddat=%h maddr=%h mdat=%h msel=%h mwe=%b",
                             got.iack, got.ierr, got.dack, got.derr, got.idat, got.ddat, got.maddr, got.mdat, got.msel, got.mwe,
                             exp.iack, exp.ierr, exp.dack, exp.derr, exp.idat, exp.ddat, exp.maddr, exp.mdat, exp.msel, exp.mwe);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #1;
        chk("rst_mcyc", 32'(mcyc_o), 32'd0);
        chk("rst_outs", {iack_o, ierr_o, dack_o, derr_o, mstb_o, mwe_o}, 32'd0);
        tick();
        rst_i = 1'b1;

        // Simultaneous requests after reset: data wins the first tie
        iaddr_i = 32'h40;
        icyc_i = 1'b1; istb_i = 1'b1;
        daddr_i = 32'h100; ddat_i = 32'hDEADBEEF; dsel_i = 4'h3; dwe_i = 1'b1;
        dcyc_i = 1'b1; dstb_i = 1'b1;
        @(negedge clk_i);
        chk("arb_latency_mcyc", 32'(mcyc_o), 32'd0);
        tick();
        @(negedge clk_i);
        chk("gntd_maddr", maddr_o, 32'h100);
        chk("gntd_mdat", mdat_o, 32'hDEADBEEF);
        chk("gntd_msel_mwe", {msel_o, mwe_o, mcyc_o, mstb_o}, {4'h3, 3'b111});
        tick();
        mack_i = 1'b1; mdat_i = 32'h5555AAAA;
        exp_q.push_back(mk(0, 0, 1, 0, 32'h0, 32'h5555AAAA, 32'h100, 32'hDEADBEEF, 4'h3, 1));
        tick();
        mack_i = 1'b0; dcyc_i = 1'b0; dstb_i = 1'b0;
        tick();
        dcyc_i = 1'b1; dstb_i = 1'b1;
        @(negedge clk_i);
        chk("idle_mcyc", 32'(mcyc_o), 32'd0);
        tick();

        // Round-robin hands the next tie to the instruction master
        @(negedge clk_i);
        chk("gnti_maddr", maddr_o, 32'h40);
        chk("gnti_fixed", {msel_o, mwe_o, mcyc_o}, {4'hf, 2'b01});
        chk("gnti_mdat", mdat_o, 32'h0);
        tick();
        mack_i = 1'b1; mdat_i = 32'h00000013;
        exp_q.push_back(mk(1, 0, 0, 0, 32'h13, 32'h0, 32'h40, 32'h0, 4'hf, 0));
        tick();
        mack_i = 1'b0; icyc_i = 1'b0; istb_i = 1'b0;
        tick();
        tick();

        // Stall timeout on the data master
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("stall_mcyc", 32'(mcyc_o), 32'd1);
            if (i == 3) exp_q.push_back(mk(0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 0));
            tick();
        end
        mack_i = 1'b1; mdat_i = 32'h12345678;
        @(negedge clk_i);
        chk("abort_mcyc", 32'(mcyc_o), 32'd0);
        chk("abort_late_ack", {dack_o, ddat_o[30:0]}, 32'd0);
        tick();
        @(negedge clk_i);
        chk("abort_err_once", {derr_o, dack_o, mcyc_o}, 32'd0);
        tick();
        mack_i = 1'b0; dcyc_i = 1'b0; dstb_i = 1'b0;
        tick();

        // Asynchronous reset in the middle of an instruction transfer
        iaddr_i = 32'h80; icyc_i = 1'b1; istb_i = 1'b1;
        tick();
        @(negedge clk_i);
        chk("pre_rst_mcyc", 32'(mcyc_o), 32'd1);
        #2;
        rst_i = 1'b0; mack_i = 1'b1;
        #1;
        chk("async_rst_mcyc", 32'(mcyc_o), 32'd0);
        chk("async_rst_iack", 32'(iack_o), 32'd0);
        mack_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        @(negedge clk_i);
        chk("post_rst_gnti", {maddr_o[7:0], msel_o, mcyc_o}, {8'h80, 4'hf, 1'b1});
        tick();

        // Ack and error together reach the owner unchanged
        mack_i = 1'b1; merr_i = 1'b1; mdat_i = 32'hCAFEF00D;
        exp_q.push_back(mk(1, 1, 0, 0, 32'hCAFEF00D, 32'h0, 32'h80, 32'h0, 4'hf, 0));
        tick();
        mack_i = 1'b0; merr_i = 1'b0; icyc_i = 1'b0; istb_i = 1'b0;
        tick();
        tick();

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
